// File: rtl/probador_pkg.sv
// Shared definitions for the equality-comparator prober: FSM state
// encoding and default operand width / settle time.
package probador_pkg;

    localparam int N_DEF      = 3;
    localparam int SETTLE_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } estado_t;

endpackage

// File: rtl/modelo_igual_ref.sv
// Reference model of the comparator under test: N-bit equality,
// purely combinational.
module modelo_igual_ref #(
    parameter int N = 3
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         igual
);

    // Golden equality result for the operands currently being driven.
    always_comb begin
        igual = (a == b);
    end

endmodule

// File: rtl/probador_igual.sv
// Exhaustive prober for an external N-bit equality comparator.
// Sweeps every (A, B) pair in ascending order, holds each pair for SETTLE
// cycles, then samples F_i and counts disagreements with the reference.
// Optional feature: PROBADOR_CAPTURA_FALLO_EN enables capture of the first
// failing operand pair; without it the fallo_* ports read as 0.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; results of the last sweep are held
// DRIVE | operands on A_o/B_o, waiting SETTLE cycles for F_i
// CHECK | sample F_i, compare with reference, advance or finish
// FIN   | one-cycle done pulse, then back to IDLE
module probador_igual
    import probador_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N-1:0]     A_o,
    output logic [N-1:0]     B_o,
    input  logic             F_i,
    output logic             busy,
    output logic             done,
    output logic [2*N:0]     errores,
    output logic             fallo_valido,
    output logic [N-1:0]     fallo_A,
    output logic [N-1:0]     fallo_B
);

    localparam int IW = 2 * N;
    localparam int EW = 2 * N + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    estado_t         estado;
    logic [IW-1:0]   indice;
    logic [CW-1:0]   cnt_settle;
    logic            esperado;
    logic            discrepancia;
    logic            arranque;

    // The index register is the operand source; A is the upper half so the
    // sweep order is A-major, B-minor.
    assign A_o = indice[IW-1:N];
    assign B_o = indice[N-1:0];

    modelo_igual_ref #(.N(N)) u_ref (
        .a     (A_o),
        .b     (B_o),
        .igual (esperado)
    );

    assign discrepancia = (estado == CHECK) && (F_i != esperado);
    assign arranque     = (estado == IDLE) && start;

    // Sweep sequencer: state, operand index, settle down-counter, status and
    // the saturating mismatch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= IDLE;
            indice     <= '0;
            cnt_settle <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            errores    <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        indice     <= '0;
                        errores    <= '0;
                        busy       <= 1'b1;
                        cnt_settle <= CNT_LOAD;
                        estado     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_settle == '0) begin
                        estado <= CHECK;
                    end else begin
                        cnt_settle <= cnt_settle - 1'b1;
                    end
                end
                CHECK: begin
                    if (discrepancia && (errores != {EW{1'b1}})) begin
                        errores <= errores + EW'(1);
                    end
                    // Stopping at the all-ones index means the index never wraps.
                    if (indice != {IW{1'b1}}) begin
                        indice     <= indice + IW'(1);
                        cnt_settle <= CNT_LOAD;
                        estado     <= DRIVE;
                    end else begin
                        done   <= 1'b1;
                        estado <= FIN;
                    end
                end
                FIN: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    estado <= IDLE;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

`ifdef PROBADOR_CAPTURA_FALLO_EN
    // First-failure capture: cleared on a new sweep, latched once per sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fallo_valido <= 1'b0;
            fallo_A      <= '0;
            fallo_B      <= '0;
        end else if (arranque) begin
            fallo_valido <= 1'b0;
            fallo_A      <= '0;
            fallo_B      <= '0;
        end else if (discrepancia && !fallo_valido) begin
            fallo_valido <= 1'b1;
            fallo_A      <= A_o;
            fallo_B      <= B_o;
        end
    end
`else
    // Capture disabled: ports kept for a stable interface, tied low.
    always_comb begin
        fallo_valido = 1'b0;
        fallo_A      = '0;
        fallo_B      = '0;
    end

    logic sin_uso;
    assign sin_uso = arranque;
`endif

endmodule

// File: tb/tb_probador_igual.sv
// Directed bench for probador_igual (N=3, SETTLE=2). The external
// comparator is modelled by a mode-selected F_i: ideal, stuck-0, stuck-1
// or inverted. Results depend on whether PROBADOR_CAPTURA_FALLO_EN is set.
module tb_probador_igual;
    import probador_pkg::*;

    localparam int N        = 3;
    localparam int SETTLE   = 2;
    localparam int NVEC     = 1 << (2 * N);
    localparam int DONE_CYC = 1 + NVEC * (SETTLE + 1);
    localparam int LIMIT    = DONE_CYC + 60;

`ifdef PROBADOR_CAPTURA_FALLO_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   A_o;
    logic [N-1:0]   B_o;
    logic           F_i;
    logic           busy;
    logic           done;
    logic [2*N:0]   errores;
    logic           fallo_valido;
    logic [N-1:0]   fallo_A;
    logic [N-1:0]   fallo_B;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    probador_igual #(.N(N), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .A_o          (A_o),
        .B_o          (B_o),
        .F_i          (F_i),
        .busy         (busy),
        .done         (done),
        .errores      (errores),
        .fallo_valido (fallo_valido),
        .fallo_A      (fallo_A),
        .fallo_B      (fallo_B)
    );

    always #5 clk = ~clk;

    // Comparator under test, selected by mode.
    always_comb begin
        case (mode)
            0:       F_i = (A_o == B_o);
            1:       F_i = 1'b0;
            2:       F_i = 1'b1;
            default: F_i = (A_o != B_o);
        endcase
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launches a sweep (start sampled at cycle 0) and watches it up to LIMIT.
    task automatic run_sweep(input int pulse_at, output int done_cyc,
                             output int n_done, output bit idx_ok);
        int cyc;
        done_cyc = -1;
        n_done   = 0;
        idx_ok   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc <= LIMIT) begin
            if (cyc < DONE_CYC && {A_o, B_o} != 6'((cyc - 1) / (SETTLE + 1)))
                idx_ok = 1'b0;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            start = (cyc == pulse_at);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int mode;
        int pulse_at;
        int err;
        bit fv;
        int fa;
        int fb;
    } vec_t;

    vec_t tabla[5];

    initial begin
        int dc;
        int nd;
        bit iok;

        tabla[0] = '{0, -1,  0, 1'b0, 0, 0};
        tabla[1] = '{1, -1,  8, CAP,  0, 0};
        tabla[2] = '{2, -1, 56, CAP,  0, CAP ? 1 : 0};
        tabla[3] = '{3, -1, 64, CAP,  0, 0};
        tabla[4] = '{0, 10,  0, 1'b0, 0, 0};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset errores", errores, 0);
        check("reset operands", {A_o, B_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            mode = tabla[i].mode;
            run_sweep(tabla[i].pulse_at, dc, nd, iok);
            check($sformatf("t%0d done cycle", i), dc, DONE_CYC);
            check($sformatf("t%0d done pulses", i), nd, 1);
            check($sformatf("t%0d errores", i), errores, tabla[i].err);
            check($sformatf("t%0d fallo_valido", i), fallo_valido, tabla[i].fv);
            check($sformatf("t%0d fallo_A", i), fallo_A, tabla[i].fa);
            check($sformatf("t%0d fallo_B", i), fallo_B, tabla[i].fb);
            check($sformatf("t%0d busy idle", i), busy, 0);
            check($sformatf("t%0d index order", i), iok, 1);
        end

        // Reset in the middle of a stuck-0 sweep.
        mode  = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check("pre-reset errores", errores, 2);
        check("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async reset busy", busy, 0);
        check("async reset errores", errores, 0);
        check("async reset operands", {A_o, B_o}, 0);
        check("async reset fallo", {fallo_valido, fallo_A, fallo_B}, 0);
        begin
            int nd_r;
            nd_r = 0;
            repeat (5) begin
                @(posedge clk);
                #1;
                if (done) nd_r++;
            end
            check("reset no done", nd_r, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 0;
        @(posedge clk);
        #1;
        run_sweep(-1, dc, nd, iok);
        check("post-reset done cycle", dc, DONE_CYC);
        check("post-reset done pulses", nd, 1);
        check("post-reset errores", errores, 0);
        check("post-reset fallo_valido", fallo_valido, 0);
        check("post-reset index order", iok, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
